// File: rtl/ahb_accel_pkg.sv
// Shared encodings for the AHB accelerator slave:
// register indices, status/control bit positions, htrans codes and FSM states.
package ahb_accel_pkg;

    typedef enum logic [2:0] {
        REG_WEIGHT  = 3'd0,
        REG_INPUT   = 3'd1,
        REG_BIAS    = 3'd2,
        REG_OUTPUT  = 3'd3,
        REG_STATUS  = 3'd4,
        REG_CONTROL = 3'd5,
        REG_ERRCLR  = 3'd6,
        REG_NONE    = 3'd7
    } reg_idx_e;

    localparam int ST_OCC_ERR  = 5;
    localparam int ST_BUS_ERR  = 6;

    localparam int CTL_LOAD    = 0;
    localparam int CTL_START   = 1;
    localparam int CTL_ACT_LSB = 2;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_e;

endpackage

// File: rtl/ahb_accel_decode.sv
// Address-phase decode: word index and classification of
// transfers that must end in an ERROR response.
module ahb_accel_decode
    import ahb_accel_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0] haddr_i,
    input  logic              hwrite_i,
    input  logic [2:0]        hsize_i,
    input  logic              occ_err_i,
    output reg_idx_e          idx_o,
    output logic              wi_o,
    output logic              err_o
);

    localparam int SH = $clog2(DATA_W / 8);
    localparam int IW = ADDR_W - SH;

    logic [IW-1:0] word;
    logic          unused_ok;

    assign word      = haddr_i[ADDR_W-1:SH];
    assign unused_ok = ^haddr_i[SH-1:0];

    always_comb begin
        idx_o = REG_NONE;
        if (word <= IW'(REG_ERRCLR)) begin
            idx_o = reg_idx_e'(word[2:0]);
        end
        wi_o  = (idx_o == REG_WEIGHT) || (idx_o == REG_INPUT);
        err_o = 1'b0;
        if (idx_o == REG_NONE) err_o = 1'b1;
        if (hwrite_i && (idx_o == REG_OUTPUT || idx_o == REG_STATUS)) err_o = 1'b1;
        if (!hwrite_i && (wi_o || idx_o == REG_ERRCLR)) err_o = 1'b1;
        if (hwrite_i && wi_o && occ_err_i) err_o = 1'b1;
        if (hsize_i > 3'(SH)) err_o = 1'b1;
    end

endmodule

// File: rtl/ahb_accel_slave.sv
// AHB-Lite slave front end for the systolic accelerator: register file,
// busy-stall handling with timeout, and two-cycle ERROR responses.
module ahb_accel_slave
    import ahb_accel_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 10,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              hsel,
    input  logic              hwrite,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hready,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic [DATA_W-1:0] weight,
    output logic [DATA_W-1:0] input_data,
    output logic [DATA_W-1:0] bias,
    output logic              weight_write_en,
    output logic              input_write_en,
    output logic              load_weights,
    output logic              start_inference,
    output logic [1:0]        activation_mode,
    input  logic              controller_busy,
    input  logic              data_ready,
    input  logic              weight_done,
    input  logic              input_done,
    input  logic              systolic_done,
    input  logic              buffer_error,
    input  logic [DATA_W-1:0] output_reg
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    state_e            state_q, state_d, pick;
    logic [CW-1:0]     cnt_q, cnt_d;
    reg_idx_e          idx_q, dec_idx;
    logic              wr_q, wi_q, dec_wi, dec_err;
    logic [DATA_W-1:0] weight_q, input_q, bias_q;
    logic [1:0]        act_q;
    logic              we_q, ie_q, lw_q, si_q, occ_q, bus_q;
    logic              accept, stall, done, wr_done;
    logic              clr_occ, clr_bus, unused_ok;

    ahb_accel_decode #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dec (
        .haddr_i  (haddr),
        .hwrite_i (hwrite),
        .hsize_i  (hsize),
        .occ_err_i(occ_q),
        .idx_o    (dec_idx),
        .wi_o     (dec_wi),
        .err_o    (dec_err)
    );

    assign unused_ok = ^hburst;
    assign stall     = wr_q && wi_q && controller_busy;

    always_comb begin
        hready = 1'b1;
        case (state_q)
            S_DATA:  hready = !stall;
            S_WAIT:  hready = !controller_busy;
            S_ERR1:  hready = 1'b0;
            default: hready = 1'b1;
        endcase
    end

    assign hresp   = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign accept  = hsel && hready &&
                     (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign pick    = accept ? (dec_err ? S_ERR1 : S_DATA) : S_IDLE;
    assign done    = hready && (state_q == S_DATA || state_q == S_WAIT);
    assign wr_done = done && wr_q;
    assign clr_occ = wr_done && (idx_q == REG_ERRCLR) && hwdata[ST_OCC_ERR];
    assign clr_bus = wr_done && (idx_q == REG_ERRCLR) && hwdata[ST_BUS_ERR];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: state_d = pick;
            S_DATA: begin
                if (stall) begin
                    cnt_d   = CW'(1);
                    state_d = (WAIT_MAX <= 1) ? S_ERR1 : S_WAIT;
                end else begin
                    state_d = pick;
                end
            end
            S_WAIT: begin
                if (controller_busy) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 >= CW'(WAIT_MAX)) state_d = S_ERR1;
                end else begin
                    state_d = pick;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = pick;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= REG_WEIGHT;
            wr_q     <= 1'b0;
            wi_q     <= 1'b0;
            weight_q <= '0;
            input_q  <= '0;
            bias_q   <= '0;
            act_q    <= '0;
            we_q     <= 1'b0;
            ie_q     <= 1'b0;
            lw_q     <= 1'b0;
            si_q     <= 1'b0;
            occ_q    <= 1'b0;
            bus_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q <= dec_idx;
                wr_q  <= hwrite;
                wi_q  <= dec_wi;
            end
            we_q  <= 1'b0;
            ie_q  <= 1'b0;
            lw_q  <= 1'b0;
            si_q  <= 1'b0;
            // a set arriving with a clear keeps the sticky bit set
            occ_q <= (occ_q & ~clr_occ) | buffer_error;
            bus_q <= (bus_q & ~clr_bus) | (state_q == S_ERR1);
            if (wr_done) begin
                case (idx_q)
                    REG_WEIGHT: begin
                        weight_q <= hwdata;
                        we_q     <= 1'b1;
                    end
                    REG_INPUT: begin
                        input_q <= hwdata;
                        ie_q    <= 1'b1;
                    end
                    REG_BIAS: bias_q <= hwdata;
                    REG_CONTROL: begin
                        lw_q  <= hwdata[CTL_LOAD];
                        si_q  <= hwdata[CTL_START];
                        act_q <= hwdata[CTL_ACT_LSB +: 2];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        hrdata = '0;
        if (state_q == S_DATA && !wr_q) begin
            case (idx_q)
                REG_BIAS:    hrdata = bias_q;
                REG_OUTPUT:  hrdata = data_ready ? output_reg : '0;
                REG_STATUS:  hrdata = DATA_W'({bus_q, occ_q, systolic_done,
                                               input_done, weight_done,
                                               data_ready, controller_busy});
                REG_CONTROL: hrdata = DATA_W'({act_q, 2'b00});
                default:     hrdata = '0;
            endcase
        end
    end

    assign weight          = weight_q;
    assign input_data      = input_q;
    assign bias            = bias_q;
    assign weight_write_en = we_q;
    assign input_write_en  = ie_q;
    assign load_weights    = lw_q;
    assign start_inference = si_q;
    assign activation_mode = act_q;

endmodule

// File: doc/ahb_accel_slave.md
AHB_ACCEL_SLAVE -- requirements
Module: ahb_accel_slave

Interface
REQ-001 The block SHALL take parameter DATA_W, default 64, the bus and register data width; legal values are 32 and 64.
REQ-002 The block SHALL take parameter ADDR_W, default 10, the haddr width.
REQ-003 The block SHALL take parameter WAIT_MAX, default 15, the maximum wait states inserted before an ERROR response.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports SHALL be, in order:
- clk  in  1  clock.
- n_rst  in  1  synchronous reset; high means reset; name kept for port compatibility.
- hsel, hwrite  in  1  AHB select and write.
- haddr  in  ADDR_W  byte address.
- htrans  in  2  transfer type.
- hsize, hburst  in  3  size and burst.
- hwdata  in  DATA_W  write data.
- hready, hresp  out  1  ready and error response.
- hrdata  out  DATA_W  read data.
- weight, input_data, bias  out  DATA_W  accelerator data.
- weight_write_en, input_write_en, load_weights, start_inference  out  1  one-cycle pulses.
- activation_mode  out  2  activation select.
- controller_busy, data_ready, weight_done, input_done, systolic_done, buffer_error  in  1  accelerator status.
- output_reg  in  DATA_W  accelerator result.

Function
REQ-006 Register map, word stride DATA_W/8 bytes, word index = haddr >> log2(DATA_W/8):
- 0 WEIGHT, write-only.
- 1 INPUT, write-only.
- 2 BIAS, read/write.
- 3 OUTPUT, read-only.
- 4 STATUS, read-only.
- 5 CONTROL, read/write.
- 6 ERRCLR, write-one-to-clear.
- Any other index is invalid.
REQ-007 An address phase SHALL be accepted when hsel=1, htrans is NONSEQ(2) or SEQ(3), and hready=1; IDLE and BUSY SHALL be accepted with an OKAY, zero-wait response and no side effect.
REQ-008 A write SHALL be captured from hwdata in the data phase; the register value or the enable pulse SHALL appear exactly one cycle after the data-phase cycle in which hready=1.
REQ-009 A write to WEIGHT or INPUT SHALL drive the matching *_write_en high for one cycle, with weight or input_data holding the written word from that cycle until the next write to it.
REQ-010 A WEIGHT or INPUT write whose data phase sees controller_busy=1 SHALL hold hready=0 until controller_busy=0, and only then complete.
REQ-011 If that wait reaches WAIT_MAX cycles, the block SHALL return ERROR and the write SHALL have no effect.
REQ-012 CONTROL layout:
- bit0 load_weights, bit1 start_inference: each write of 1 gives a one-cycle pulse, and the bit reads back 0.
- bits3:2 activation_mode, held.
REQ-013 STATUS layout:
- bits0-4: controller_busy, data_ready, weight_done, input_done, systolic_done, read live.
- bit5 occ_err, sticky copy of buffer_error.
- bit6 bus_err, sticky, set by any ERROR response.
- Other bits 0.
REQ-014 Writing 1 to ERRCLR bit5 or bit6 SHALL clear the matching sticky bit; a set and a clear in the same cycle SHALL leave the bit set.
REQ-015 hrdata SHALL be valid in the data phase of a read with zero wait states.
REQ-016 A read of BIAS or CONTROL immediately after a write to the same register SHALL return the new value, using forwarding.
REQ-017 A read of OUTPUT when data_ready=0 SHALL return 0 with OKAY.
REQ-018 The following SHALL each produce ERROR:
- an invalid index;
- a write to OUTPUT or STATUS;
- a read of WEIGHT, INPUT or ERRCLR;
- hsize > log2(DATA_W/8);
- a WEIGHT or INPUT write while occ_err=1.
REQ-019 ERROR response SHALL last two cycles: first hready=0, hresp=1; then hready=1, hresp=1. A transfer presented during the first cycle SHALL be ignored.
REQ-020 Bursts (hburst INCR/INCR4/INCR8/WRAP4) SHALL be handled beat by beat through REQ-007 to REQ-019; a back-to-back WEIGHT burst SHALL give one weight_write_en per beat with no bubbles while controller_busy=0.
REQ-021 Data-phase state machine states: IDLE, DATA, WAIT, ERR1, ERR2.
- DATA->WAIT on busy stall.
- WAIT->DATA when controller_busy=0.
- WAIT->ERR1 on timeout.
- Any state->ERR1 on an error condition.
- ERR1->ERR2, then ERR2->IDLE, or ERR2->DATA when a new transfer is pending.

Reset
REQ-022 While n_rst=1 at a clk edge, the block SHALL reset: state IDLE, hready=1, hresp=0, hrdata=0, all data registers 0, activation_mode=0, all pulses 0, sticky bits 0.
REQ-023 A reset during WAIT or ERR1 SHALL abandon the transfer with no enable pulse.

Structure
REQ-024 The register index enumeration, STATUS/CONTROL bit positions, htrans encodings and state enumeration SHALL be defined in package ahb_accel_pkg.
REQ-025 Address decode and error classification SHALL be in sub-module ahb_accel_decode (combinational); all sequential logic stays in ahb_accel_slave.

Verification
REQ-026 The bench SHALL cover these directed scenarios, with DATA_W=64:
- Write 0xA5 to 0x000 with busy=0 -> weight_write_en=1 for one cycle; weight=0xA5; zero waits; OKAY.
- Write 0x3 to 0x010, then read 0x010 back-to-back -> hrdata=0x3 (forwarding).
- INPUT write with busy high for 3 cycles -> hready low 3 cycles, then input_write_en pulse; busy high 15 cycles -> two-cycle ERROR, no pulse, STATUS bit6=1.
- Read 0x3F8 (invalid) -> ERR1 then ERR2; write 0x40 to ERRCLR -> STATUS bit6=0.
- INCR4 WEIGHT burst, busy=0 -> four consecutive weight_write_en pulses carrying beat data in order.
- Write CONTROL 0xB -> load_weights and start_inference pulse one cycle; activation_mode=2; CONTROL reads back 0x8. Assert n_rst mid-WAIT -> all outputs reset, no enable pulse.
